// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// Two-stage branch resolution unit with a small in-order result queue.
//
// Ports:
//   clk_in, rst_in         clock and synchronous active-low reset
//   flush_in               kills the op in S1 and every queued result
//   valid_in / ready_out   issue handshake from the branch reservation station
//   brFunc_in, is_jalr_in  branch function and jalr select (Dbr only)
//   rval1_in, rval2_in     operands
//   pc_in, imm_in          branch PC and sign-extended immediate
//   tag_in                 ROB tag
//   pred_taken_in          front-end predicted direction
//   pred_target_in         front-end predicted target
//   valid_out / ready_in   result handshake with the common data bus
//   tag_out, taken_out     head result tag and resolved direction
//   target_out             resolved next PC (target if taken, else pc+4)
//   link_out               pc+4 writeback value
//   mispredict_out         head result disagrees with the prediction
// -----------------------------------------------------------------------------
package branch_unit_pkg;
  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NEQ = 3'd1,
    BR_LT  = 3'd2,
    BR_LTU = 3'd3,
    BR_GE  = 3'd4,
    BR_GEU = 3'd5,
    BR_DBR = 3'd6
  } BrFunc;
endpackage

module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  BrFunc            brFunc_in,
  input  logic             is_jalr_in,
  input  logic [XLEN-1:0]  rval1_in,
  input  logic [XLEN-1:0]  rval2_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             pred_taken_in,
  input  logic [XLEN-1:0]  pred_target_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [TAG_W-1:0] tag_out,
  output logic             taken_out,
  output logic [XLEN-1:0]  target_out,
  output logic [XLEN-1:0]  link_out,
  output logic             mispredict_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // S1 operand registers
  logic             s1_valid;
  BrFunc            s1_func;
  logic             s1_jalr;
  logic [XLEN-1:0]  s1_rval1;
  logic [XLEN-1:0]  s1_rval2;
  logic [XLEN-1:0]  s1_pc;
  logic [XLEN-1:0]  s1_imm;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_pred_taken;
  logic [XLEN-1:0]  s1_pred_target;

  // Result queue storage; target holds the already-selected next PC
  logic [TAG_W-1:0] q_tag    [DEPTH];
  logic             q_taken  [DEPTH];
  logic [XLEN-1:0]  q_target [DEPTH];
  logic [XLEN-1:0]  q_link   [DEPTH];
  logic             q_mis    [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  // S2 resolve signals
  logic             s2_taken;
  logic [XLEN-1:0]  s2_target;
  logic [XLEN-1:0]  s2_link;
  logic [XLEN-1:0]  s2_next_pc;
  logic             s2_mis;
  logic [XLEN-1:0]  sum_pc;
  logic [XLEN-1:0]  sum_reg;

  logic issue_fire;
  logic enq;
  logic deq;

  // The S1 op is counted against the queue so an accepted op always finds
  // a free slot; a dequeue in the same cycle is deliberately not credited.
  assign ready_out  = ({1'b0, count} + {{CNT_W{1'b0}}, s1_valid}) < (CNT_W+1)'(DEPTH);
  assign issue_fire = valid_in && ready_out && !flush_in;
  assign valid_out  = (count != '0);
  assign enq        = s1_valid;
  assign deq        = valid_out && ready_in;

  // S1 captures an accepted issue; an issue in a flush cycle is dropped.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_valid       <= 1'b0;
      s1_func        <= BR_EQ;
      s1_jalr        <= 1'b0;
      s1_rval1       <= '0;
      s1_rval2       <= '0;
      s1_pc          <= '0;
      s1_imm         <= '0;
      s1_tag         <= '0;
      s1_pred_taken  <= 1'b0;
      s1_pred_target <= '0;
    end else begin
      s1_valid <= issue_fire;
      if (issue_fire) begin
        s1_func        <= brFunc_in;
        s1_jalr        <= is_jalr_in;
        s1_rval1       <= rval1_in;
        s1_rval2       <= rval2_in;
        s1_pc          <= pc_in;
        s1_imm         <= imm_in;
        s1_tag         <= tag_in;
        s1_pred_taken  <= pred_taken_in;
        s1_pred_target <= pred_target_in;
      end
    end
  end

  // S2 resolves the condition, target, link and mispredict from S1.
  // Encodings outside the enum fall to the default and resolve not taken.
  always_comb begin
    s2_taken = 1'b0;
    case (s1_func)
      BR_EQ:   s2_taken = (s1_rval1 == s1_rval2);
      BR_NEQ:  s2_taken = (s1_rval1 != s1_rval2);
      BR_LT:   s2_taken = ($signed(s1_rval1) <  $signed(s1_rval2));
      BR_GE:   s2_taken = ($signed(s1_rval1) >= $signed(s1_rval2));
      BR_LTU:  s2_taken = (s1_rval1 <  s1_rval2);
      BR_GEU:  s2_taken = (s1_rval1 >= s1_rval2);
      BR_DBR:  s2_taken = 1'b1;
      default: s2_taken = 1'b0;
    endcase
  end

  assign sum_pc     = s1_pc + s1_imm;
  assign sum_reg    = s1_rval1 + s1_imm;
  assign s2_link    = s1_pc + XLEN'(4);
  assign s2_target  = (s1_func == BR_DBR && s1_jalr) ? {sum_reg[XLEN-1:1], 1'b0} : sum_pc;
  assign s2_next_pc = s2_taken ? s2_target : s2_link;
  // A correctly predicted not-taken branch ignores the predicted target.
  assign s2_mis     = (s2_taken != s1_pred_taken) ||
                      (s2_taken && (s2_target != s1_pred_target));

  // Circular result queue; flush resets the pointers but keeps the storage,
  // while reset clears the storage as well so the outputs read zero.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_tag[i]    <= '0;
        q_taken[i]  <= 1'b0;
        q_target[i] <= '0;
        q_link[i]   <= '0;
        q_mis[i]    <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        q_tag[tail]    <= s1_tag;
        q_taken[tail]  <= s2_taken;
        q_target[tail] <= s2_next_pc;
        q_link[tail]   <= s2_link;
        q_mis[tail]    <= s2_mis;
        tail           <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  assign tag_out        = q_tag[head];
  assign taken_out      = q_taken[head];
  assign target_out     = q_target[head];
  assign link_out       = q_link[head];
  assign mispredict_out = q_mis[head];

endmodule

// File: doc/branch_unit.md
# branch_unit

Pipelined, parametrised branch resolution unit for the out-of-order core, generalising the combinational branch comparator. It accepts issued branch and jump micro-ops from the branch reservation station over a valid/ready handshake and resolves the condition, target address and link value. It detects mispredictions against the front-end prediction and buffers results in a DEPTH-entry queue until the common data bus grants a broadcast slot. Operands are XLEN-wide, and results carry a TAG_W-bit ROB tag.

## Interface
- XLEN, 32: operand, PC and target width.
- TAG_W, 4: ROB tag width.
- DEPTH, 4: result queue entries (power of two, ≥2).
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  synchronous, active-low reset.
- flush_in  in  1  pipeline flush; kills all in-flight and queued results.
- valid_in  in  1  issue request.
- ready_out  out  1  unit can accept an issue this cycle.
- brFunc_in  in  BrFunc  Eq, Neq, Lt, Ltu, Ge, Geu, Dbr.
- is_jalr_in  in  1  with Dbr: target from rval1; otherwise from pc.
- rval1_in, rval2_in  in  XLEN  operands, signed view for Lt/Ge.
- pc_in, imm_in  in  XLEN  branch PC and sign-extended immediate.
- tag_in  in  TAG_W  ROB tag.
- pred_taken_in  in  1  front-end predicted direction.
- pred_target_in  in  XLEN  front-end predicted target.
- valid_out  out  1  queue head valid.
- ready_in  in  1  CDB grant; head dequeues when valid_out && ready_in.
- tag_out  out  TAG_W  head tag.
- taken_out  out  1  resolved direction.
- target_out  out  XLEN  resolved next PC: target if taken, else pc+4.
- link_out  out  XLEN  pc+4, the jal/jalr writeback value.
- mispredict_out  out  1  head was mispredicted.

## Operation
- Stage S1 (operand register): captures all inputs when valid_in && ready_out; s1_valid set.
- Stage S2 (resolve): condition, adders and mispredict logic on S1 registers; result written into the queue at the next edge.
- Condition evaluation:
  - Eq, Neq: equality.
  - Lt, Ge: signed compare.
  - Ltu, Geu: unsigned compare.
  - Dbr: always taken.
  - Encodings outside the enum: not taken.
- Target:
  - Dbr with is_jalr: (rval1+imm) & ~1.
  - Otherwise: pc+imm.
  - All sums are modulo 2^XLEN with no overflow flag.
- Outputs:
  - target_out = taken ? target : pc+4.
  - link_out = pc+4 for every op.
- mispredict = (taken != pred_taken) || (taken && target != pred_target). A correctly predicted not-taken branch never mispredicts, whatever pred_target is.
- Queue: circular buffer of DEPTH entries with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH. Results leave in issue order.
- Back-pressure:
  - ready_out = (count + s1_valid) < DEPTH, so any accepted op always has a queue slot.
  - Credit for a same-cycle dequeue is not taken.
- Simultaneous enqueue and dequeue: count unchanged. When the queue is full, enqueue cannot occur by construction.
- Flush, when flush_in=1:
  - s1_valid, count, head and tail are cleared at the edge.
  - An issue presented in the same cycle is dropped.
  - A dequeue in the same cycle still counts as delivered to the CDB.
- Reset, when rst_in=0: same as flush, plus all data registers are zeroed. This holds mid-operation too.

## Timing
- After reset:
  - valid_out=0, ready_out=1.
  - tag_out, taken_out, target_out, link_out and mispredict_out are all 0.
  - Outputs are driven from queue head storage, which reset zeroes.
- Latency:
  - An issue accepted at edge N sits in S1 during cycle N.
  - It is enqueued at edge N+1.
  - valid_out is high in cycle N+1, i.e. 2 edges from presentation to visibility.
- Throughput: one issue per cycle while ready_out=1 and ready_in=1 every cycle; steady state count ≤1.
- ready_out is combinational from registered state only; it does not depend on valid_in or ready_in.
- Output fields are stable while valid_out=1 && ready_in=0.
- Hold: valid_in may be held across cycles with ready_out=0; the op is taken on the first cycle ready_out=1.

## Test plan
- Compare sweep: rval1=0xFFFFFFFF, rval2=0x00000001, with ready_in=1.
  - Lt → taken=1; Ltu → 0; Ge → 0; Geu → 1.
  - Eq → 0; Neq → 1.
  - Each result appears 2 edges after issue.
- Jalr target: Dbr, is_jalr=1, rval1=0x1003, imm=0x4, pc=0x200, pred_taken=1, pred_target=0x1006.
  - Expect target_out=0x1006, link_out=0x204, mispredict=0.
  - Same op with pred_target=0x1008 → mispredict=1.
- Wrap and not-taken: pc=0xFFFFFFFC with Neq on equal operands.
  - Expect target_out=0x00000000 and taken=0.
  - With pred_taken=0 and pred_target=0x1234 → mispredict=0.
- Back-pressure: hold ready_in=0 and issue 5 ops with tags 1..5 (DEPTH=4).
  - ready_out drops after 3 accepts plus 1 in S1.
  - Raise ready_in → tags emerge 1,2,3,4 in order, then 5 is accepted and emerges.
  - No duplicates or loss.
- Flush and reset: queue 3 results, then pulse flush_in with valid_in=1 in the same cycle.
  - Next cycle: valid_out=0, ready_out=1, and the flush-cycle op is never output.
  - Repeat with rst_in=0 mid-stream → all outputs 0.
